shreg_delay_ctrl: RTL and testbench

Controller plus storage for a variable-length, clock-enabled delay line (SRL-style shift register) of `WIDTH`-bit samples, up to `DEPTH` stages. It sequences the shift register from a valid/ready input stream and selects the output tap from a runtime length configured over a handshake. It tracks fill level so that only genuine samples are presented downstream. It sits between a sample source and a consumer that needs a programmable sample delay.

---
 rtl/shreg_delay_ctrl.sv | 146 ++++++++++++++
 tb/tb_shreg_delay_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shreg_delay_ctrl.sv
// Programmable-length delay line for a valid/ready sample stream. Only the control
// path is reset, so the sample storage can still map onto SRL primitives.
//
// state  | meaning
// -------+----------------------------------------------------------------
// FILL   | fewer than len genuine samples stored; accepted samples emit nothing
// RUN    | at least len samples stored; every accepted sample emits next cycle
// SETTLE | one cycle after a length update; stream and config both stalled
module shreg_delay_ctrl #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 130,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             cfg_valid,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_SETTLE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_nxt;
    logic [LEN_W-1:0] len_clamped;
    logic             cfg_clamped;
    logic             err_pend;
    logic             in_acc;
    logic             cfg_acc;
    logic             emit;
    logic [WIDTH-1:0] tap;

    // The live input is tap 1, so DEPTH-1 stored stages give DEPTH selectable taps.
    logic [WIDTH-1:0] sr [DEPTH-1];

    always_comb begin
        in_ready  = !r && (state != S_SETTLE);
        cfg_ready = !r && (state != S_SETTLE);
    end

    assign in_acc  = in_valid & in_ready;
    assign cfg_acc = cfg_valid & cfg_ready;

    always_comb begin
        len_clamped = cfg_len;
        cfg_clamped = 1'b0;
        if (cfg_len == '0) begin
            len_clamped = LEN_ONE;
            cfg_clamped = 1'b1;
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
            cfg_clamped = 1'b1;
        end
    end

    always_comb begin
        fill_nxt = fill;
        if (clear) begin
            fill_nxt = in_acc ? LEN_ONE : '0;
        end else if (in_acc && (fill != LEN_MAX)) begin
            fill_nxt = fill + LEN_ONE;
        end
    end

    // Uses the length in force before any update accepted on this same edge.
    assign emit = in_acc && (fill_nxt >= len);

    always_comb begin
        tap = in_data;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (len == LEN_W'(i + 2)) begin
                tap = sr[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL, S_RUN: begin
                if (cfg_acc) begin
                    state_nxt = S_SETTLE;
                end else begin
                    state_nxt = (fill_nxt >= len) ? S_RUN : S_FILL;
                end
            end
            S_SETTLE: begin
                state_nxt = (fill_nxt >= len) ? S_RUN : S_FILL;
            end
            default: begin
                state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state     <= S_FILL;
            len       <= LEN_MAX;
            fill      <= '0;
            err_pend  <= 1'b0;
            cfg_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            fill      <= fill_nxt;
            if (cfg_acc) begin
                len <= len_clamped;
            end
            err_pend  <= cfg_acc & cfg_clamped;
            cfg_err   <= err_pend;
            out_valid <= emit;
            if (emit) begin
                out_data <= tap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_acc) begin
            sr[0] <= in_data;
            for (int i = 1; i < DEPTH - 1; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_shreg_delay_ctrl.sv
// Bench for shreg_delay_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_shreg_delay_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 130;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             r;
    logic             cfg_valid;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    shreg_delay_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .r         (r),
        .cfg_valid (cfg_valid),
        .cfg_len   (cfg_len),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: history of accepted samples (newest first) plus counters.
    logic [WIDTH-1:0] hist[$];
    int               m_len;
    int               m_fill;
    bit               m_settle;
    bit               m_e1;
    bit               exp_err;
    bit               exp_ov;
    logic [WIDTH-1:0] exp_od;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit acc_in;
        bit acc_cfg;
        int nf;
        if (r) begin
            m_len    = DEPTH;
            m_fill   = 0;
            m_settle = 1'b0;
            m_e1     = 1'b0;
            exp_err  = 1'b0;
            exp_ov   = 1'b0;
            exp_od   = '0;
        end else begin
            acc_in  = in_valid && !m_settle;
            acc_cfg = cfg_valid && !m_settle;
            exp_err = m_e1;
            m_e1    = acc_cfg && (cfg_len == 0 || cfg_len > DEPTH);
            if (acc_in) begin
                hist.push_front(in_data);
                if (hist.size() > DEPTH) void'(hist.pop_back());
            end
            if (clear) nf = acc_in ? 1 : 0;
            else       nf = (m_fill + int'(acc_in) > DEPTH) ? DEPTH : m_fill + int'(acc_in);
            exp_ov = acc_in && (nf >= m_len);
            if (exp_ov) exp_od = hist[m_len-1];
            m_fill = nf;
            if (acc_cfg) m_len = (cfg_len == 0) ? 1 : ((cfg_len > DEPTH) ? DEPTH : int'(cfg_len));
            m_settle = acc_cfg;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic do_cfg(input logic [LEN_W-1:0] l);
        in_valid  = 1'b0;
        cfg_valid = 1'b1;
        cfg_len   = l;
        tick();
        cfg_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, int'(!r && !m_settle));
            chk("cfg_ready", cfg_ready, int'(!r && !m_settle));
            chk("out_valid", out_valid, int'(exp_ov));
            if (exp_ov) chk("out_data", out_data, int'(exp_od));
            chk("cfg_err", cfg_err, int'(exp_err));
        end
    end

    initial begin
        r         = 1'b1;
        cfg_valid = 1'b0;
        cfg_len   = '0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        tick();
        chk_en = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        tick();
        r = 1'b0;

        // Full-length delay: first output after the 130th sample.
        for (int i = 0; i < 135; i++) begin
            send(WIDTH'(i));
            if (i >= 128) chk("t1_ov", out_valid, int'(i >= 129));
            if (i >= 129) chk("t1_od", out_data, i - 129);
        end
        chk("t1_model_od", exp_od, 5);
        in_valid = 1'b0;

        r = 1'b1;
        tick();
        r = 1'b0;

        // Shorten to 4 after 10 samples.
        for (int i = 0; i < 10; i++) send(WIDTH'(i));
        do_cfg(8'd4);
        chk("t2_settle_in_ready", in_ready, 0);
        chk("t2_settle_cfg_ready", cfg_ready, 0);
        tick();
        chk("t2_in_ready_back", in_ready, 1);
        send(8'd10);
        chk("t2_ov", out_valid, 1);
        chk("t2_od", out_data, 7);

        // Lengthen to 50 with fill=20.
        for (int i = 11; i < 20; i++) send(WIDTH'(i));
        do_cfg(8'd50);
        tick();
        for (int i = 20; i < 50; i++) begin
            send(WIDTH'(i));
            chk("t3_ov", out_valid, int'(i == 49));
            if (i == 49) chk("t3_od", out_data, 0);
        end

        // Clamps.
        do_cfg(8'd0);
        chk("t4_err_early", cfg_err, 0);
        tick();
        chk("t4_err", cfg_err, 1);
        send(8'hA5);
        chk("t4_ov", out_valid, 1);
        chk("t4_od", out_data, 8'hA5);
        chk("t4_err_done", cfg_err, 0);
        send(8'h3C);
        chk("t4_od2", out_data, 8'h3C);
        do_cfg(8'd200);
        tick();
        chk("t4b_err", cfg_err, 1);
        send(8'h11);
        chk("t4b_ov", out_valid, 0);

        // Clear coincident with an accept at L=3.
        do_cfg(8'd3);
        tick();
        send(8'h01);
        send(8'h02);
        chk("t5_od_pre", out_data, 8'h11);
        clear = 1'b1;
        send(8'h77);
        clear = 1'b0;
        chk("t5_ov_clear", out_valid, 0);
        send(8'h01);
        chk("t5_ov_a", out_valid, 0);
        send(8'h02);
        chk("t5_ov_b", out_valid, 1);
        chk("t5_od", out_data, 8'h77);

        // Reset mid-RUN with in_valid held high.
        send(8'h04);
        r       = 1'b1;
        in_data = 8'h05;
        tick();
        chk("t6_ov_rst", out_valid, 0);
        chk("t6_in_ready_rst", in_ready, 0);
        r = 1'b0;
        for (int i = 0; i < 130; i++) begin
            send(WIDTH'(i + 50));
            if (i >= 127) chk("t6_ov", out_valid, int'(i == 129));
        end
        chk("t6_od", out_data, 50);
        in_valid = 1'b0;

        // Randomized traffic.
        repeat (4000) begin
            r         = ($urandom_range(0, 299) == 0);
            cfg_valid = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: cfg_len = LEN_W'($urandom_range(0, 10));
                5, 6, 7:       cfg_len = LEN_W'($urandom_range(0, 140));
                default:       cfg_len = LEN_W'($urandom_range(0, 255));
            endcase
            clear    = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 9) < 8);
            in_data  = WIDTH'($urandom);
            tick();
        end
        r         = 1'b0;
        cfg_valid = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
